// File: rtl/matrix_input_module_pkg.sv
// Shared definitions for the matrix operand entry block and its debouncer.
//   state_t              : entry FSM encoding (IDLE=0, LOAD=1, DONE=2, VALID=3)
//   IDX_A11 .. IDX_B22   : entry_idx value that selects each operand register
//   DEFAULT_DEBOUNCE_CYCLES : 10 ms at 100 MHz, shared by every board button
package matrix_input_module_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_VALID = 2'd3
  } state_t;

  localparam logic [2:0] IDX_A11 = 3'd0;
  localparam logic [2:0] IDX_A12 = 3'd1;
  localparam logic [2:0] IDX_A21 = 3'd2;
  localparam logic [2:0] IDX_A22 = 3'd3;
  localparam logic [2:0] IDX_B11 = 3'd4;
  localparam logic [2:0] IDX_B12 = 3'd5;
  localparam logic [2:0] IDX_B21 = 3'd6;
  localparam logic [2:0] IDX_B22 = 3'd7;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/matrix_input_module_if.sv
// Bus between the operand entry block and the surrounding board logic.
//   sw_data, btn_load, load_en : inputs to the entry block
//   a_*/b_*                    : the eight 8-bit operands
//   entry_idx                  : next entry to capture, for the display
//   busy / load_done / matrix_valid : controller status
// Modports: slave = the entry block, master = whoever drives it.
interface matrix_input_module_if;
  logic [7:0] sw_data;
  logic       btn_load;
  logic       load_en;
  logic [7:0] a_11, a_12, a_21, a_22;
  logic [7:0] b_11, b_12, b_21, b_22;
  logic [2:0] entry_idx;
  logic       busy;
  logic       load_done;
  logic       matrix_valid;

  modport slave (
    input  sw_data, btn_load, load_en,
    output a_11, a_12, a_21, a_22, b_11, b_12, b_21, b_22,
    output entry_idx, busy, load_done, matrix_valid
  );

  modport master (
    output sw_data, btn_load, load_en,
    input  a_11, a_12, a_21, a_22, b_11, b_12, b_21, b_22,
    input  entry_idx, busy, load_done, matrix_valid
  );
endinterface

// File: rtl/matrix_input_module_button_debouncer.sv
// Push-button conditioner: two-flop synchronizer, debounce counter and
// rising-edge detector.
//   clk, rst    : clock, asynchronous active-high reset
//   btn_raw     : raw asynchronous button
//   btn_stable  : debounced level
//   press_pulse : one-cycle pulse on each accepted press (release is silent)
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_stable,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q, stable_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    stable_dly_d = stable_q;
    stable_d     = stable_q;
    cnt_d        = '0;
    // The counter only runs while the synchronized level disagrees with the
    // accepted one; any agreeing cycle restarts the qualification window.
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q        <= cnt_d;
    end
  end

  assign btn_stable  = stable_q;
  assign press_pulse = stable_q & ~stable_dly_q;

endmodule

// File: rtl/matrix_input_module.sv
// Operand entry block: the operator keys two 2x2 8-bit matrices in from the
// slide switches, one entry per debounced press of btn_load.
//   clk, rst : 100 MHz clock, asynchronous active-high reset
//   bus      : matrix_input_module_if.slave (switches, button, load_en in;
//              eight operands, entry_idx, busy, load_done, matrix_valid out)
module matrix_input_module
  import matrix_input_module_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  matrix_input_module_if.slave  bus
);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] ops_q [8];
  logic [7:0] ops_d [8];
  logic       press_pulse;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn_load (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (bus.btn_load),
    .btn_stable  (),
    .press_pulse (press_pulse)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ops_d   = ops_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.load_en) begin
          state_d = ST_LOAD;
          idx_d   = IDX_A11;
        end
      end
      ST_LOAD: begin
        if (press_pulse) begin
          ops_d[idx_q] = bus.sw_data;
          if (idx_q == IDX_B22) begin
            idx_d   = IDX_A11;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_DONE: state_d = ST_VALID;
      ST_VALID: begin
        // A restart request outranks a press landing in the same cycle;
        // presses are never captured here anyway.
        if (bus.load_en) begin
          state_d = ST_LOAD;
          idx_d   = IDX_A11;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      for (int i = 0; i < 8; i++) ops_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ops_q   <= ops_d;
    end
  end

  // Status outputs are decoded straight from the state register so they
  // clear the instant rst asserts.
  assign bus.busy         = (state_q == ST_LOAD);
  assign bus.load_done    = (state_q == ST_DONE);
  assign bus.matrix_valid = (state_q == ST_VALID);
  assign bus.entry_idx    = idx_q;

  assign bus.a_11 = ops_q[IDX_A11];
  assign bus.a_12 = ops_q[IDX_A12];
  assign bus.a_21 = ops_q[IDX_A21];
  assign bus.a_22 = ops_q[IDX_A22];
  assign bus.b_11 = ops_q[IDX_B11];
  assign bus.b_12 = ops_q[IDX_B12];
  assign bus.b_21 = ops_q[IDX_B21];
  assign bus.b_22 = ops_q[IDX_B22];

endmodule

// File: tb/tb_matrix_input_module.sv
// Self-checking bench for matrix_input_module with DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_matrix_input_module;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  matrix_input_module_if bus();

  matrix_input_module #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] ops [8];
  assign ops[0] = bus.a_11;
  assign ops[1] = bus.a_12;
  assign ops[2] = bus.a_21;
  assign ops[3] = bus.a_22;
  assign ops[4] = bus.b_11;
  assign ops[5] = bus.b_12;
  assign ops[6] = bus.b_21;
  assign ops[7] = bus.b_22;

  always @(negedge clk) if (bus.load_done) done_cnt++;

  typedef struct {
    logic [7:0] sw;
    int         slot;
    logic [2:0] exp_idx;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] sw);
    bus.sw_data  = sw;
    bus.btn_load = 1'b1;
    cycles(10);
    bus.btn_load = 1'b0;
    cycles(10);
  endtask

  task automatic pulse_load_en();
    bus.load_en = 1'b1;
    cycles(1);
    bus.load_en = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'd123, 0, 3'd1};
    vecs[1] = '{8'd159, 1, 3'd2};
    vecs[2] = '{8'd198, 2, 3'd3};
    vecs[3] = '{8'd255, 3, 3'd4};
    vecs[4] = '{8'd1,   4, 3'd5};
    vecs[5] = '{8'd2,   5, 3'd6};
    vecs[6] = '{8'd3,   6, 3'd7};
    vecs[7] = '{8'd4,   7, 3'd0};

    // Reset with switches and button active
    rst = 1'b1;
    bus.sw_data  = 8'hFF;
    bus.btn_load = 1'b1;
    bus.load_en  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) check($sformatf("reset_op%0d", i), ops[i], 0);
      check("reset_idx", bus.entry_idx, 0);
      check("reset_status", {bus.busy, bus.load_done, bus.matrix_valid}, 0);
    end
    bus.btn_load = 1'b0;
    rst = 1'b0;
    cycles(10);
    check("idle_status", {bus.busy, bus.load_done, bus.matrix_valid}, 0);

    // Full load from the vector table
    pulse_load_en();
    check("load_busy", bus.busy, 1);
    check("load_idx0", bus.entry_idx, 0);
    for (int i = 0; i < 8; i++) begin
      press(vecs[i].sw);
      check($sformatf("full_op%0d", vecs[i].slot), ops[vecs[i].slot], vecs[i].sw);
      check($sformatf("full_idx_after%0d", i), bus.entry_idx, vecs[i].exp_idx);
    end
    check("full_done_pulses", done_cnt, 1);
    check("full_valid", bus.matrix_valid, 1);
    check("full_busy", bus.busy, 0);
    check("full_load_done_low", bus.load_done, 0);
    for (int i = 0; i < 8; i++) check($sformatf("full_recheck_op%0d", i), ops[i], vecs[i].sw);

    // Press in VALID is ignored
    press(8'h99);
    check("valid_press_ignored_a11", bus.a_11, 123);
    check("valid_press_ignored_idx", bus.entry_idx, 0);

    // Restart; old operands retained
    pulse_load_en();
    check("restart_busy", bus.busy, 1);
    check("restart_valid", bus.matrix_valid, 0);
    check("restart_keep_a11", bus.a_11, 123);

    // Glitch of 3 synchronized cycles: no capture
    bus.sw_data  = 8'h77;
    bus.btn_load = 1'b1;
    cycles(3);
    bus.btn_load = 1'b0;
    cycles(15);
    check("glitch3_idx", bus.entry_idx, 0);
    check("glitch3_a11", bus.a_11, 123);

    // 4 cycles is just long enough to be accepted
    bus.sw_data  = 8'h33;
    bus.btn_load = 1'b1;
    cycles(4);
    bus.btn_load = 1'b0;
    cycles(15);
    check("pulse4_idx", bus.entry_idx, 1);
    check("pulse4_a11", bus.a_11, 8'h33);

    // Latency and hold: first high sample at edge 0, capture on edge 6
    bus.sw_data  = 8'h5A;
    bus.btn_load = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k == 5) check("lat_edge5_a12", bus.a_12, 159);
      if (k == 6) check("lat_edge6_a12", bus.a_12, 8'h5A);
    end
    check("hold_idx", bus.entry_idx, 2);
    check("hold_a21", bus.a_21, 198);
    bus.btn_load = 1'b0;
    cycles(10);

    // Finish this load to reach VALID
    for (int i = 2; i < 8; i++) press(8'h10 + 8'(i));
    check("reload_valid", bus.matrix_valid, 1);
    check("reload_b22", bus.b_22, 8'h17);

    // Restart collision: load_en sampled on the same edge as press_pulse
    bus.sw_data  = 8'hEE;
    bus.btn_load = 1'b1;
    cycles(6);
    bus.load_en = 1'b1;
    cycles(1);
    bus.load_en = 1'b0;
    check("coll_busy", bus.busy, 1);
    check("coll_idx", bus.entry_idx, 0);
    check("coll_valid", bus.matrix_valid, 0);
    check("coll_a11", bus.a_11, 8'h33);
    cycles(20);
    bus.btn_load = 1'b0;
    cycles(10);
    check("coll_idx_later", bus.entry_idx, 0);
    check("coll_b22", bus.b_22, 8'h17);

    // Mid-load asynchronous reset
    press(8'h11);
    press(8'h22);
    press(8'h44);
    check("mid_idx3", bus.entry_idx, 3);
    check("mid_a21", bus.a_21, 8'h44);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_a11", bus.a_11, 0);
    check("arst_a12", bus.a_12, 0);
    check("arst_a21", bus.a_21, 0);
    check("arst_b22", bus.b_22, 0);
    check("arst_idx", bus.entry_idx, 0);
    check("arst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    cycles(5);
    press(8'h55);
    check("idle_press_a11", bus.a_11, 0);
    check("idle_press_idx", bus.entry_idx, 0);
    check("idle_status_end", {bus.busy, bus.load_done, bus.matrix_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_input_module.md
Name: matrix_input_module

Overview:
- Front-end operand entry block: the operator loads two 2x2 8-bit matrices (A and B) from 8 slide switches, one entry per debounced button press.
- Produces the eight operand registers consumed by the systolic-array and custom datapaths, whose results go to display_module.
- Signals the top-level controller with a done pulse and a valid level.
- Forms the input end of the board I/O chain; display_module is the output end.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a synchronized button level must differ from the stable level before it is accepted (10 ms at 100 MHz).
- CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- sw_data  in  8  raw slide-switch value (quasi-static; sampled directly, not synchronized).
- btn_load  in  1  raw asynchronous push-button.
- load_en  in  1  one-cycle request from the controller to start or restart entry.
- a_11, a_12, a_21, a_22  out  8 each  matrix A operands.
- b_11, b_12, b_21, b_22  out  8 each  matrix B operands.
- entry_idx  out  3  index of the next entry to capture (0..7), for the display.
- busy  out  1  high in LOAD.
- load_done  out  1  one-cycle pulse when the 8th entry is captured.
- matrix_valid  out  1  level; high in VALID.

Behaviour:
- Reset (async, rst=1): all operand registers 0, entry_idx 0, busy 0, load_done 0, matrix_valid 0, FSM in IDLE, sync flops 0, stable level 0, counter 0.
- Synchronizer: btn_load passes through two flops, sync1 then sync2.
- Debounce counter:
  - While sync2 != stable, counter increments each cycle.
  - When counter == DEBOUNCE_CYCLES-1 and the mismatch persists: stable <= sync2, counter <= 0.
  - Any cycle with sync2 == stable sets counter <= 0.
- Press detection: press_pulse = stable & ~stable_d, where stable_d is stable delayed one cycle. The release edge generates nothing.
- Latency: edge 0 is the first edge at which btn_load is sampled high. With the button held, the operand register updates on edge DEBOUNCE_CYCLES+2.
- Glitches: a high glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no press.
- Entry order by entry_idx: 0=a_11, 1=a_12, 2=a_21, 3=a_22, 4=b_11, 5=b_12, 6=b_21, 7=b_22.
- FSM states: IDLE, LOAD, DONE, VALID.
  - IDLE: load_en -> LOAD, entry_idx <= 0. Presses ignored.
  - LOAD (busy=1): on press_pulse, register[entry_idx] <= sw_data and entry_idx increments.
  - LOAD, press at entry_idx==7: capture b_22, entry_idx wraps to 0, go to DONE.
  - LOAD: load_en is ignored.
  - DONE: load_done=1 for exactly one cycle, then VALID.
  - VALID (matrix_valid=1): presses ignored. load_en -> LOAD, matrix_valid <= 0, entry_idx <= 0. Operand registers keep old values until overwritten.
  - load_en and press_pulse in the same cycle in VALID: restart wins; the press is not captured.
  - load_en in DONE: ignored.
- Button held through multiple entries: exactly one capture per debounced press.
- Async reset mid-LOAD: everything returns to reset values immediately, including partially loaded registers.
- Operand registers change only on a capture or on reset.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit: IDLE=0, LOAD=1, DONE=2, VALID=3).
  - Entry index constants IDX_A11..IDX_B22.
  - The default DEBOUNCE_CYCLES value, shared with other board-input blocks.
- One sub-module: button_debouncer.
  - Parameters: DEBOUNCE_CYCLES, CNT_W.
  - Ports: clk, rst, btn_raw -> btn_stable, press_pulse.
  - Contains the synchronizer, debounce counter and edge detector.
  - Reused for any further board buttons.

Test Plan:
- Run all scenarios with DEBOUNCE_CYCLES=4.
- Reset: rst=1 for 20 ns with sw_data=8'hFF and btn_load=1 -> all operands 0, entry_idx 0, busy/load_done/matrix_valid 0 throughout.
- Full load: pulse load_en, then 8 clean presses (btn high 10 cycles, low 10 cycles) with sw_data 123,159,198,255,1,2,3,4 -> a_11=123, a_12=159, a_21=198, a_22=255, b_11..b_22=1..4. Additionally:
  - load_done is a single-cycle pulse after the 8th capture.
  - matrix_valid=1 afterwards.
  - entry_idx=0.
- Glitch reject: in LOAD, btn high for 3 synchronized cycles -> no capture, entry_idx unchanged.
- Latency/hold: btn rises and is held 50 cycles with sw_data=8'h5A -> register written exactly on edge 6 after first high sample; only one capture; entry_idx advances by 1.
- Restart collision: in VALID, assert load_en in the same cycle as a press_pulse -> state LOAD, entry_idx 0, no register written, matrix_valid 0.
- Mid-load reset: capture 3 entries, assert rst asynchronously between clock edges -> outputs clear immediately (before the next edge), FSM IDLE.
